n64_pi_initiator: RTL

- Console-side (RCP) initiator for the N64 Parallel Interface bus. It drives ALEH/ALEL, the read/write strobes and the multiplexed AD bus toward a cartridge-side PI responder.
- Accepts single burst commands (address, direction, halfword count) from an internal command port. Streams write data in, and read data out, one 16-bit halfword at a time.
- Used for on-board loopback/self-test of the cartridge PI path and as the synthesizable bus driver in system-level benches.

---
 rtl/n64_pi_initiator.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/n64_pi_initiator.sv
// Console-side N64 Parallel Interface initiator: drives ALEH/ALEL, strobes and the AD bus
// for single-command bursts, with every pin output registered and one shared phase timer.
module n64_pi_initiator #(
  parameter int T_ALE     = 4,
  parameter int T_SETUP   = 8,
  parameter int T_STROBE  = 8,
  parameter int T_RECOVER = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_address,
  input  logic [7:0]  cmd_length,
  input  logic [15:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        pi_aleh,
  output logic        pi_alel,
  output logic        pi_read,
  output logic        pi_write,
  output logic [15:0] pi_ad_out,
  output logic        pi_ad_oe,
  input  logic [15:0] pi_ad_in
);

  localparam logic [7:0] ALE_LOAD     = 8'(T_ALE - 1);
  localparam logic [7:0] SETUP_LOAD   = 8'(T_SETUP - 1);
  localparam logic [7:0] STROBE_LOAD  = 8'(T_STROBE - 1);
  localparam logic [7:0] RECOVER_LOAD = 8'(T_RECOVER - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ALE_HI, S_ALE_LO, S_SETUP, S_STROBE, S_RECOVER, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic        write_q, write_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        wdata_ready_q, wdata_ready_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        busy_q, busy_d;
  logic        aleh_q, aleh_d;
  logic        alel_q, alel_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [15:0] ad_out_q, ad_out_d;
  logic        ad_oe_q, ad_oe_d;

  assign cmd_ready   = cmd_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign busy        = busy_q;
  assign pi_aleh     = aleh_q;
  assign pi_alel     = alel_q;
  assign pi_read     = rd_q;
  assign pi_write    = wr_q;
  assign pi_ad_out   = ad_out_q;
  assign pi_ad_oe    = ad_oe_q;

  // Next-state and next-pin computation; pins change only on phase boundaries.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    len_d         = len_q;
    write_d       = write_q;
    cmd_ready_d   = cmd_ready_q;
    wdata_ready_d = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    busy_d        = busy_q;
    aleh_d        = aleh_q;
    alel_d        = alel_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    ad_out_d      = ad_out_q;
    ad_oe_d       = ad_oe_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = S_ALE_HI;
          cnt_d       = ALE_LOAD;
          addr_d      = cmd_address & 32'hFFFF_FFFE;
          len_d       = cmd_length;
          write_d     = cmd_write;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          aleh_d      = 1'b1;
          alel_d      = 1'b1;
          ad_oe_d     = 1'b1;
          ad_out_d    = cmd_address[31:16];
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      S_ALE_HI: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d  = S_ALE_LO;
          cnt_d    = ALE_LOAD;
          aleh_d   = 1'b0;
          ad_out_d = addr_q[15:0];
        end
      end
      S_ALE_LO: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LOAD;
          alel_d  = 1'b0;
          ad_oe_d = write_q;
        end
      end
      S_SETUP: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (write_q && !wdata_valid) begin
          cnt_d = cnt_q;
        end else begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LOAD;
          if (write_q) begin
            wdata_ready_d = 1'b1;
            ad_out_d      = wdata;
            wr_d          = 1'b0;
          end else begin
            rd_d = 1'b0;
          end
        end
      end
      S_STROBE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_RECOVER;
          cnt_d   = RECOVER_LOAD;
          rd_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = addr_q + 32'd2;
          // The responder still drives AD during this last low cycle, so capture it here.
          if (!write_q) begin
            rdata_d       = pi_ad_in;
            rdata_valid_d = 1'b1;
          end else begin
            rdata_d = rdata_q;
          end
        end
      end
      S_RECOVER: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (len_q == 8'd0) begin
          state_d = S_DONE;
        end else if (write_q && !wdata_valid) begin
          cnt_d = cnt_q;
        end else begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LOAD;
          len_d   = len_q - 8'd1;
          if (write_q) begin
            wdata_ready_d = 1'b1;
            ad_out_d      = wdata;
            wr_d          = 1'b0;
          end else begin
            rd_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        ad_oe_d     = 1'b0;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, timer and registered pin outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      addr_q        <= 32'd0;
      len_q         <= 8'd0;
      write_q       <= 1'b0;
      cmd_ready_q   <= 1'b0;
      wdata_ready_q <= 1'b0;
      rdata_q       <= 16'd0;
      rdata_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      aleh_q        <= 1'b0;
      alel_q        <= 1'b0;
      rd_q          <= 1'b1;
      wr_q          <= 1'b1;
      ad_out_q      <= 16'd0;
      ad_oe_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      write_q       <= write_d;
      cmd_ready_q   <= cmd_ready_d;
      wdata_ready_q <= wdata_ready_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      busy_q        <= busy_d;
      aleh_q        <= aleh_d;
      alel_q        <= alel_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      ad_out_q      <= ad_out_d;
      ad_oe_q       <= ad_oe_d;
    end
  end

endmodule
